// File: rtl/tempest_bus_pkg.sv
// Shared bus-cycle definitions for the host-side 6502 bus master.
// State encoding, bus widths and the data returned on an aborted read.
package tempest_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] RD_TIMEOUT_DATA = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FREEZE,
        ST_ACCESS,
        ST_STRETCH,
        ST_DONE
    } bus_state_e;

endpackage

// File: rtl/bus_cyc_counter.sv
// cyc_en-qualified up counter; term flags the enable that brings the count to LIMIT.
// Used for the CPU-freeze hold count and the bus_wait timeout count.
module bus_cyc_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = en && (count_q == LAST);

endmodule

// File: rtl/bus_cycle_master.sv
// Host-side initiator of 6502-style bus cycles (debug peek/poke, RAM load with the T65 frozen).
// Optional burst auto-increment is enabled by defining BURST_AUTOINC_EN.
module bus_cycle_master
    import tempest_bus_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic              clk_96MHz,
    input  logic              RESET,
    input  logic              cyc_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_len,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              cpu_freeze,
    output logic              bus_own,
    output logic [ADDR_W-1:0] bus_A,
    output logic              bus_R_Wn,
    output logic [DATA_W-1:0] bus_Dout,
    input  logic [DATA_W-1:0] bus_Din,
    input  logic              bus_wait
);

    bus_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              cpu_freeze_q, cpu_freeze_d;
    logic              bus_own_q, bus_own_d;
    logic [ADDR_W-1:0] bus_A_q, bus_A_d;
    logic              bus_R_Wn_q, bus_R_Wn_d;
    logic [DATA_W-1:0] bus_Dout_q, bus_Dout_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic       accept;
    logic       finish;
    logic       abort;
    logic       last_beat;
    logic       hold_en, hold_term;
    logic       tmo_en, tmo_clr, tmo_term;
    logic [7:0] unused_hold_cnt;
    logic [7:0] unused_tmo_cnt;

    // A cyc_en in the accept clock sees ST_IDLE, so it never counts toward the hold.
    assign accept  = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign hold_en = cyc_en && (state_q == ST_FREEZE);
    assign tmo_clr = cyc_en && (state_q == ST_ACCESS) && bus_wait;
    assign tmo_en  = cyc_en && (state_q == ST_STRETCH) && bus_wait;

    bus_cyc_counter #(
        .WIDTH (8),
        .LIMIT (HOLD_CYCLES)
    ) u_hold_cnt (
        .clk   (clk_96MHz),
        .rst   (RESET),
        .clr   (accept),
        .en    (hold_en),
        .count (unused_hold_cnt),
        .term  (hold_term)
    );

    bus_cyc_counter #(
        .WIDTH (8),
        .LIMIT (TIMEOUT)
    ) u_tmo_cnt (
        .clk   (clk_96MHz),
        .rst   (RESET),
        .clr   (tmo_clr),
        .en    (tmo_en),
        .count (unused_tmo_cnt),
        .term  (tmo_term)
    );

`ifdef BURST_AUTOINC_EN
    logic [7:0] beats_q, beats_d;

    always_comb begin
        beats_d = beats_q;
        if (accept) begin
            beats_d = req_len;
        end else if (finish && !abort && !last_beat) begin
            beats_d = beats_q - 8'd1;
        end
    end

    always_ff @(posedge clk_96MHz or posedge RESET) begin
        if (RESET) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end

    assign last_beat = (beats_q == '0);
`else
    logic unused_req_len;
    assign unused_req_len = ^req_len;
    assign last_beat      = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        cpu_freeze_d  = cpu_freeze_q;
        bus_own_d     = bus_own_q;
        bus_A_d       = bus_A_q;
        bus_R_Wn_d    = bus_R_Wn_q;
        bus_Dout_d    = bus_Dout_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        finish        = 1'b0;
        abort         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d      = req_write;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    req_ready_d  = 1'b0;
                    cpu_freeze_d = 1'b1;
                    state_d      = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                if (hold_term) begin
                    bus_own_d  = 1'b1;
                    bus_A_d    = addr_q;
                    bus_R_Wn_d = !write_q;
                    bus_Dout_d = wdata_q;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cyc_en) begin
                    if (bus_wait) begin
                        state_d = ST_STRETCH;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            ST_STRETCH: begin
                if (cyc_en) begin
                    if (!bus_wait) begin
                        finish = 1'b1;
                    end else if (tmo_term) begin
                        finish = 1'b1;
                        abort  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Bus still owned here only when another burst beat follows.
                if (bus_own_q) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d       = ST_DONE;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = abort;
            if (abort) begin
                rsp_rdata_d = RD_TIMEOUT_DATA;
            end else if (write_q) begin
                rsp_rdata_d = '0;
            end else begin
                rsp_rdata_d = bus_Din;
            end
            if (abort || last_beat) begin
                bus_own_d    = 1'b0;
                bus_R_Wn_d   = 1'b1;
                cpu_freeze_d = 1'b0;
            end else begin
                bus_A_d = bus_A_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_96MHz or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            cpu_freeze_q  <= 1'b0;
            bus_own_q     <= 1'b0;
            bus_A_q       <= '0;
            bus_R_Wn_q    <= 1'b1;
            bus_Dout_q    <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            cpu_freeze_q  <= cpu_freeze_d;
            bus_own_q     <= bus_own_d;
            bus_A_q       <= bus_A_d;
            bus_R_Wn_q    <= bus_R_Wn_d;
            bus_Dout_q    <= bus_Dout_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign cpu_freeze  = cpu_freeze_q;
    assign bus_own     = bus_own_q;
    assign bus_A       = bus_A_q;
    assign bus_R_Wn    = bus_R_Wn_q;
    assign bus_Dout    = bus_Dout_q;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed bench for bus_cycle_master: vector table of single requests plus reset/burst sequences.
// The burst sequence is compiled when BURST_AUTOINC_EN is defined.
module tb_bus_cycle_master;

    localparam int unsigned HOLD = 2;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        cyc_en = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic [7:0]  req_len = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        cpu_freeze;
    logic        bus_own;
    logic [15:0] bus_A;
    logic        bus_R_Wn;
    logic [7:0]  bus_Dout;
    logic [7:0]  bus_Din = '0;
    logic        bus_wait = 1'b0;

    int tests = 0;
    int fails = 0;
    int rsp_cnt = 0;
    int own_drops = 0;
    bit own_watch = 1'b0;

    bus_cycle_master #(
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (255)
    ) dut (
        .clk_96MHz   (clk),
        .RESET       (RESET),
        .cyc_en      (cyc_en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_len     (req_len),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .cpu_freeze  (cpu_freeze),
        .bus_own     (bus_own),
        .bus_A       (bus_A),
        .bus_R_Wn    (bus_R_Wn),
        .bus_Dout    (bus_Dout),
        .bus_Din     (bus_Din),
        .bus_wait    (bus_wait)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt++;
        if (own_watch && !bus_own) own_drops++;
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  len;
        logic [7:0]  din;
        int unsigned wait_n;
        logic        cyc_at_accept;
        logic [7:0]  exp_rdata;
        logic        exp_to;
        int unsigned exp_pulses;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cyc_en pulse, three idle clocks before it; returns at the negedge after the pulse edge.
    task automatic cyc();
        repeat (3) @(negedge clk);
        cyc_en = 1'b1;
        @(negedge clk);
        cyc_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned n;
        bit seen;
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_len   = v.len;
        cyc_en    = v.cyc_at_accept;
        @(negedge clk);
        req_valid = 1'b0;
        cyc_en    = 1'b0;
        check("ready_busy", req_ready, 0);
        check("freeze_on", cpu_freeze, 1);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 300) begin
            n++;
            bus_wait = (n >= HOLD + 1) && (n < HOLD + 1 + v.wait_n);
            bus_Din  = v.din;
            cyc();
            if (n == HOLD - 1) check("own_during_hold", bus_own, 0);
            if (n == HOLD) begin
                check("own_at_access", bus_own, 1);
                check("addr_at_access", bus_A, v.addr);
                check("rwn_at_access", bus_R_Wn, !v.wr);
                if (v.wr) check("dout_at_access", bus_Dout, v.wdata);
            end
            if (rsp_valid) seen = 1'b1;
        end
        bus_wait = 1'b0;
        check("rsp_seen", seen, 1);
        check("rsp_pulses", n, v.exp_pulses);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_timeout", rsp_timeout, v.exp_to);
        check("freeze_at_rsp", cpu_freeze, 0);
        check("own_at_rsp", bus_own, 0);
        check("rwn_at_rsp", bus_R_Wn, 1);
        @(negedge clk);
        check("rsp_one_clk", rsp_valid, 0);
        check("ready_after", req_ready, 1);
    endtask

    initial begin
        int base;
        vec_t v;
        // wr addr wdata len din wait cyc@acc exp_rdata exp_to pulses
        vecs[0] = '{1'b0, 16'h0803, 8'h00, 8'd0, 8'h5A, 0,   1'b0, 8'h5A, 1'b0, 3};
        vecs[1] = '{1'b1, 16'h2000, 8'hC3, 8'd0, 8'h77, 0,   1'b0, 8'h00, 1'b0, 3};
        vecs[2] = '{1'b0, 16'h1234, 8'h00, 8'd0, 8'h11, 4,   1'b0, 8'h11, 1'b0, 7};
        vecs[3] = '{1'b0, 16'h4000, 8'h00, 8'd0, 8'h22, 999, 1'b0, 8'hFF, 1'b1, 258};
        vecs[4] = '{1'b0, 16'h5555, 8'h00, 8'd0, 8'h66, 255, 1'b0, 8'h66, 1'b0, 258};
        vecs[5] = '{1'b1, 16'hFFFF, 8'h3C, 8'd0, 8'h44, 1,   1'b0, 8'h00, 1'b0, 4};
        vecs[6] = '{1'b0, 16'h0100, 8'h00, 8'd0, 8'hA5, 0,   1'b1, 8'hA5, 1'b0, 3};

        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_freeze", cpu_freeze, 0);
        check("rst_rwn", bus_R_Wn, 1);
        RESET = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Reset while stretched: everything back to reset values, no response.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h6789;
        req_wdata = 8'h5F;
        @(negedge clk);
        req_valid = 1'b0;
        bus_wait  = 1'b1;
        repeat (5) cyc();
        base = rsp_cnt;
        RESET = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rdata", rsp_rdata, 8'h00);
        check("mid_rst_timeout", rsp_timeout, 0);
        check("mid_rst_freeze", cpu_freeze, 0);
        check("mid_rst_own", bus_own, 0);
        check("mid_rst_addr", bus_A, 16'h0000);
        check("mid_rst_rwn", bus_R_Wn, 1);
        check("mid_rst_dout", bus_Dout, 8'h00);
        RESET = 1'b0;
        bus_wait = 1'b0;
        @(negedge clk);
        check("mid_rst_no_rsp", rsp_cnt - base, 0);
        run_vec(vecs[0]);

`ifdef BURST_AUTOINC_EN
        begin
            logic [15:0] exp_a [4];
            exp_a[0] = 16'hFFFE;
            exp_a[1] = 16'hFFFF;
            exp_a[2] = 16'h0000;
            exp_a[3] = 16'h0001;
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 16'hFFFE;
            req_wdata = 8'h99;
            req_len   = 8'd3;
            @(negedge clk);
            req_valid = 1'b0;
            cyc();
            cyc();
            base = rsp_cnt;
            own_drops = 0;
            own_watch = 1'b1;
            for (int b = 0; b < 4; b++) begin
                check("burst_addr", bus_A, exp_a[b]);
                check("burst_rwn", bus_R_Wn, 0);
                check("burst_dout", bus_Dout, 8'h99);
                if (b == 3) own_watch = 1'b0;
                cyc();
                check("burst_rsp", rsp_valid, 1);
                check("burst_rdata", rsp_rdata, 8'h00);
            end
            check("burst_rsp_count", rsp_cnt - base, 4);
            check("burst_own_drops", own_drops, 0);
            check("burst_own_end", bus_own, 0);
            check("burst_freeze_end", cpu_freeze, 0);
            @(negedge clk);
            check("burst_ready_end", req_ready, 1);
            req_len = 8'd0;
        end
`else
        v = vecs[0];
        v.len = 8'd3;
        base = rsp_cnt;
        run_vec(v);
        repeat (6) cyc();
        check("len_ignored_rsp_count", rsp_cnt - base, 1);
        check("len_ignored_ready", req_ready, 1);
        check("len_ignored_own", bus_own, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
